// File: rtl/writeback_arbiter_if.sv
// rtl/writeback_arbiter_if.sv - result handshakes, scoreboard queries and register-file write port of writeback_arbiter
interface writeback_arbiter_if;
    logic        alu_valid;
    logic        alu_ready;
    logic [4:0]  alu_rd;
    logic [31:0] alu_value;
    logic        lsu_valid;
    logic        lsu_ready;
    logic [4:0]  lsu_rd;
    logic [31:0] lsu_value;
    logic        pend_set;
    logic [4:0]  pend_rd;
    logic [4:0]  query1_key;
    logic [4:0]  query2_key;
    logic        query1_busy;
    logic        query2_busy;
    logic        portD_enable;
    logic [4:0]  portD_key;
    logic [31:0] portD_value;

    modport slave (
        input  alu_valid, alu_rd, alu_value, lsu_valid, lsu_rd, lsu_value,
        input  pend_set, pend_rd, query1_key, query2_key,
        output alu_ready, lsu_ready, query1_busy, query2_busy,
        output portD_enable, portD_key, portD_value
    );

    modport master (
        output alu_valid, alu_rd, alu_value, lsu_valid, lsu_rd, lsu_value,
        output pend_set, pend_rd, query1_key, query2_key,
        input  alu_ready, lsu_ready, query1_busy, query2_busy,
        input  portD_enable, portD_key, portD_value
    );
endinterface

// File: rtl/writeback_arbiter.sv
// rtl/writeback_arbiter.sv - merges ALU/LSU results onto the register-file write port with a load scoreboard
// Optional LSU starvation guard enabled by defining WB_STARVE_GUARD_EN.
module writeback_arbiter #(
    parameter int LSU_FIFO_DEPTH = 2,
    parameter int STARVE_LIMIT   = 4
) (
    input  logic               clk,
    input  logic               reset,
    writeback_arbiter_if.slave wb
);
    localparam int AW = $clog2(LSU_FIFO_DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW + 1)'(LSU_FIFO_DEPTH);

    logic [4:0]    fifo_rd    [LSU_FIFO_DEPTH];
    logic [31:0]   fifo_value [LSU_FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic [31:0]   pending;
    logic [31:0]   pending_next;
    logic          d_enable;
    logic          d_lsu;
    logic [4:0]    d_key;
    logic [31:0]   d_value;
    logic          fifo_empty;
    logic          fifo_full;
    logic          alu_ready;
    logic          lsu_ready;
    logic          alu_fire;
    logic          lsu_fire;
    logic          alu_claims;
    logic          pop;
    logic          bypass;
    logic          push;
    logic          src_valid;
    logic          src_lsu;
    logic [4:0]    src_rd;
    logic [31:0]   src_value;

    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == FULL_COUNT);
    assign lsu_ready  = !fifo_full && !reset;

`ifdef WB_STARVE_GUARD_EN
    localparam int CW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] LIMIT_COUNT = CW'(STARVE_LIMIT);
    logic [CW-1:0] starve_cnt;

    assign alu_ready = (starve_cnt != LIMIT_COUNT);

    always_ff @(posedge clk) begin
        if (reset) begin
            starve_cnt <= '0;
        end else if (fifo_empty || pop) begin
            starve_cnt <= '0;
        end else if (alu_claims) begin
            starve_cnt <= starve_cnt + CW'(1);
        end
    end
`else
    // Always 1 for any legal STARVE_LIMIT: the ALU wins unconditionally.
    assign alu_ready = (STARVE_LIMIT > 0);
`endif

    // A forced LSU cycle needs no extra term: alu_ready=0 leaves the port to the FIFO head.
    // An rd-0 ALU result is consumed without claiming the port.
    always_comb begin
        alu_fire   = wb.alu_valid && alu_ready;
        lsu_fire   = wb.lsu_valid && lsu_ready;
        alu_claims = alu_fire && (wb.alu_rd != 5'd0);
        pop        = !fifo_empty && !alu_claims;
        bypass     = lsu_fire && fifo_empty && !alu_claims;
        push       = lsu_fire && !bypass;
        src_valid  = 1'b1;
        src_lsu    = 1'b1;
        src_rd     = fifo_rd[rd_ptr];
        src_value  = fifo_value[rd_ptr];
        if (alu_claims) begin
            src_lsu   = 1'b0;
            src_rd    = wb.alu_rd;
            src_value = wb.alu_value;
        end else if (pop) begin
            src_lsu   = 1'b1;
        end else if (bypass) begin
            src_rd    = wb.lsu_rd;
            src_value = wb.lsu_value;
        end else begin
            src_valid = 1'b0;
        end
    end

    // Clear first so a same-cycle set of the same register wins.
    always_comb begin
        pending_next = pending;
        if (d_enable && d_lsu) begin
            pending_next[d_key] = 1'b0;
        end
        if (wb.pend_set && (wb.pend_rd != 5'd0)) begin
            pending_next[wb.pend_rd] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_rd[wr_ptr]    <= wb.lsu_rd;
            fifo_value[wr_ptr] <= wb.lsu_value;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            pending  <= '0;
            d_enable <= 1'b0;
            d_lsu    <= 1'b0;
            d_key    <= '0;
            d_value  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push && !pop) begin
                count <= count + (AW + 1)'(1);
            end else if (pop && !push) begin
                count <= count - (AW + 1)'(1);
            end
            pending  <= pending_next;
            d_enable <= src_valid && (src_rd != 5'd0);
            d_lsu    <= src_lsu;
            if (src_valid && (src_rd != 5'd0)) begin
                d_key   <= src_rd;
                d_value <= src_value;
            end
        end
    end

    assign wb.alu_ready    = alu_ready;
    assign wb.lsu_ready    = lsu_ready;
    assign wb.portD_enable = d_enable;
    assign wb.portD_key    = d_key;
    assign wb.portD_value  = d_value;
    assign wb.query1_busy  = pending[wb.query1_key] && (wb.query1_key != 5'd0);
    assign wb.query2_busy  = pending[wb.query2_key] && (wb.query2_key != 5'd0);
endmodule

// File: tb/tb_writeback_arbiter.sv
// tb/tb_writeback_arbiter.sv - directed and randomized checks of writeback_arbiter against a queue-based model
module tb_writeback_arbiter;
    localparam int DEPTH = 2;
    localparam int LIMIT = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    writeback_arbiter_if wb ();

    writeback_arbiter #(.LSU_FIFO_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
        .clk   (clk),
        .reset (reset),
        .wb    (wb)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] value;
    } ent_t;

    ent_t        mq[$];
    logic [31:0] m_pend = '0;
    logic        m_en = 1'b0;
    logic        m_lsu = 1'b0;
    logic [4:0]  m_key = '0;
    logic [31:0] m_val = '0;
    int          m_wins = 0;
    bit          model_live = 1'b0;

    function automatic bit exp_alu_ready();
`ifdef WB_STARVE_GUARD_EN
        return m_wins != LIMIT;
`else
        return 1'b1;
`endif
    endfunction

    function automatic bit exp_lsu_ready();
        return (mq.size() < DEPTH) && !reset;
    endfunction

    function automatic void model_write(input logic [4:0] rd, input logic [31:0] value, input bit from_lsu);
        if (rd != 5'd0) begin
            m_en  = 1'b1;
            m_lsu = from_lsu;
            m_key = rd;
            m_val = value;
        end
    endfunction

    // Reference: results either go straight to the port or wait in an ordered queue.
    always @(posedge clk) begin : model
        bit   a_acc;
        bit   l_acc;
        bit   a_takes;
        bit   was_empty;
        bit   popped;
        bit   bypassed;
        ent_t e;
        model_live = 1'b1;
        if (reset) begin
            mq.delete();
            m_pend = '0;
            m_en   = 1'b0;
            m_lsu  = 1'b0;
            m_key  = '0;
            m_val  = '0;
            m_wins = 0;
        end else begin
            a_acc     = wb.alu_valid && exp_alu_ready();
            l_acc     = wb.lsu_valid && exp_lsu_ready();
            a_takes   = a_acc && (wb.alu_rd != 5'd0);
            was_empty = (mq.size() == 0);
            if (m_en && m_lsu) m_pend[m_key] = 1'b0;
            if (wb.pend_set && wb.pend_rd != 5'd0) m_pend[wb.pend_rd] = 1'b1;
            m_en = 1'b0;
            popped = 1'b0;
            bypassed = 1'b0;
            if (!a_takes && !was_empty) begin
                e = mq.pop_front();
                popped = 1'b1;
                model_write(e.rd, e.value, 1'b1);
            end else if (a_takes) begin
                model_write(wb.alu_rd, wb.alu_value, 1'b0);
            end else if (l_acc) begin
                bypassed = 1'b1;
                model_write(wb.lsu_rd, wb.lsu_value, 1'b1);
            end
            if (l_acc && !bypassed) mq.push_back({wb.lsu_rd, wb.lsu_value});
            if (was_empty || popped) m_wins = 0;
            else if (a_takes) m_wins++;
        end
    end

    always @(negedge clk) begin
        if (model_live) begin
            check("alu_ready", {31'd0, wb.alu_ready}, {31'd0, exp_alu_ready()});
            check("lsu_ready", {31'd0, wb.lsu_ready}, {31'd0, exp_lsu_ready()});
            check("portD_enable", {31'd0, wb.portD_enable}, {31'd0, m_en});
            if (m_en) begin
                check("portD_key", {27'd0, wb.portD_key}, {27'd0, m_key});
                check("portD_value", wb.portD_value, m_val);
            end
            check("query1_busy", {31'd0, wb.query1_busy},
                  {31'd0, m_pend[wb.query1_key] && (wb.query1_key != 5'd0)});
            check("query2_busy", {31'd0, wb.query2_busy},
                  {31'd0, m_pend[wb.query2_key] && (wb.query2_key != 5'd0)});
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wb.alu_valid = 1'b0;
        wb.lsu_valid = 1'b0;
        wb.pend_set  = 1'b0;
    endtask

    task automatic drive_alu(input logic [4:0] rd, input logic [31:0] value);
        wb.alu_valid = 1'b1;
        wb.alu_rd    = rd;
        wb.alu_value = value;
    endtask

    task automatic drive_lsu(input logic [4:0] rd, input logic [31:0] value);
        wb.lsu_valid = 1'b1;
        wb.lsu_rd    = rd;
        wb.lsu_value = value;
    endtask

    logic [4:0] got[$];
    logic [4:0] want[$];
    int         lsu_idx;
    int         accepts;
    int         first_stall;

    initial begin
        wb.alu_valid = 1'b0; wb.alu_rd = '0; wb.alu_value = '0;
        wb.lsu_valid = 1'b0; wb.lsu_rd = '0; wb.lsu_value = '0;
        wb.pend_set = 1'b0; wb.pend_rd = '0;
        wb.query1_key = '0; wb.query2_key = '0;

        repeat (3) step();
        @(negedge clk);
        check("rst_lsu_ready", {31'd0, wb.lsu_ready}, 32'd0);
        check("rst_alu_ready", {31'd0, wb.alu_ready}, 32'd1);
        check("rst_portD_enable", {31'd0, wb.portD_enable}, 32'd0);
        check("rst_portD_key", {27'd0, wb.portD_key}, 32'd0);
        check("rst_portD_value", wb.portD_value, 32'd0);
        step(); reset = 1'b0;
        @(negedge clk);
        check("post_rst_lsu_ready", {31'd0, wb.lsu_ready}, 32'd1);

        step(); drive_alu(5'd5, 32'hDEADBEEF);
        step(); idle();
        @(negedge clk);
        check("alu_enable", {31'd0, wb.portD_enable}, 32'd1);
        check("alu_key", {27'd0, wb.portD_key}, 32'd5);
        check("alu_value", wb.portD_value, 32'hDEADBEEF);

        step(); wb.pend_set = 1'b1; wb.pend_rd = 5'd7; wb.query1_key = 5'd7;
        step(); wb.pend_set = 1'b0; drive_lsu(5'd7, 32'h0000_7777);
        @(negedge clk);
        check("pend7_busy", {31'd0, wb.query1_busy}, 32'd1);
        step(); idle();
        @(negedge clk);
        check("bypass_enable", {31'd0, wb.portD_enable}, 32'd1);
        check("bypass_key", {27'd0, wb.portD_key}, 32'd7);
        check("pend7_busy_still", {31'd0, wb.query1_busy}, 32'd1);
        step();
        @(negedge clk);
        check("pend7_cleared", {31'd0, wb.query1_busy}, 32'd0);

        got.delete();
        lsu_idx = 0; accepts = 0; first_stall = -1;
        for (int c = 0; c < 10; c++) begin
            step();
            if (c < 3) drive_alu(5'(c + 1), 32'h100 + 32'(c));
            else wb.alu_valid = 1'b0;
            if (lsu_idx < 3) drive_lsu(5'(9 + lsu_idx), 32'h900 + 32'(lsu_idx));
            else wb.lsu_valid = 1'b0;
            @(negedge clk);
            if (wb.portD_enable) got.push_back(wb.portD_key);
            if (wb.lsu_valid && !wb.lsu_ready && first_stall < 0) first_stall = accepts;
            if (wb.lsu_valid && wb.lsu_ready) begin
                lsu_idx++;
                accepts++;
            end
        end
        idle();
        check("stall_after_enqueues", 32'(first_stall), 32'd2);
        want = '{5'd1, 5'd2, 5'd3, 5'd9, 5'd10, 5'd11};
        check("order_count", 32'(got.size()), 32'd6);
        for (int k = 0; k < 6; k++) begin
            check("order_key", {27'd0, (k < got.size()) ? got[k] : 5'd0}, {27'd0, want[k]});
        end

        step(); drive_lsu(5'd3, 32'h33);
        step(); idle(); wb.pend_set = 1'b1; wb.pend_rd = 5'd3; wb.query2_key = 5'd3;
        step(); wb.pend_set = 1'b0;
        @(negedge clk);
        check("set_wins_busy", {31'd0, wb.query2_busy}, 32'd1);
        step(); drive_alu(5'd0, 32'hABCD);
        step(); idle();
        @(negedge clk);
        check("alu_rd0_enable", {31'd0, wb.portD_enable}, 32'd0);
        step(); drive_lsu(5'd0, 32'h1234);
        step(); idle();
        @(negedge clk);
        check("lsu_rd0_enable", {31'd0, wb.portD_enable}, 32'd0);

`ifdef WB_STARVE_GUARD_EN
        got.delete();
        lsu_idx = 1; accepts = 0;
        step(); drive_alu(5'd1, 32'h1); drive_lsu(5'd30, 32'h30);
        for (int c = 0; c < 9; c++) begin
            @(negedge clk);
            if (!wb.alu_ready) accepts++;
            if (wb.alu_ready) lsu_idx++;
            step();
            wb.lsu_valid = 1'b0;
            drive_alu(5'(lsu_idx), 32'(lsu_idx));
            @(negedge clk);
            if (wb.portD_enable) got.push_back(wb.portD_key);
            #1;
        end
        idle();
        want = '{5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd30, 5'd6};
        check("starve_forced_cycles", 32'(accepts), 32'd1);
        for (int k = 0; k < 7; k++) begin
            check("starve_key", {27'd0, (k < got.size()) ? got[k] : 5'd0}, {27'd0, want[k]});
        end
`endif

        repeat (4) step();
        step(); drive_alu(5'd1, 32'h11); drive_lsu(5'd20, 32'h20); wb.pend_set = 1'b1; wb.pend_rd = 5'd20;
        step(); drive_alu(5'd2, 32'h22); drive_lsu(5'd21, 32'h21); wb.pend_set = 1'b0;
        step(); idle(); reset = 1'b1; wb.query1_key = 5'd20; wb.query2_key = 5'd3;
        @(negedge clk);
        check("pre_rst_busy20", {31'd0, wb.query1_busy}, 32'd1);
        check("pre_rst_lsu_ready", {31'd0, wb.lsu_ready}, 32'd0);
        step();
        @(negedge clk);
        check("mid_rst_enable", {31'd0, wb.portD_enable}, 32'd0);
        check("mid_rst_busy1", {31'd0, wb.query1_busy}, 32'd0);
        check("mid_rst_busy2", {31'd0, wb.query2_busy}, 32'd0);
        step(); reset = 1'b0;
        @(negedge clk);
        check("after_rst_lsu_ready", {31'd0, wb.lsu_ready}, 32'd1);

        for (int i = 0; i < 3000; i++) begin
            step();
            reset = ($urandom_range(0, 299) == 0);
            wb.alu_valid  = ($urandom_range(0, 9) < 6);
            wb.alu_rd     = 5'($urandom_range(0, 7));
            wb.alu_value  = $urandom;
            wb.lsu_valid  = ($urandom_range(0, 9) < 5);
            wb.lsu_rd     = 5'($urandom_range(0, 7));
            wb.lsu_value  = $urandom;
            wb.pend_set   = ($urandom_range(0, 9) < 3);
            wb.pend_rd    = 5'($urandom_range(0, 7));
            wb.query1_key = 5'($urandom_range(0, 7));
            wb.query2_key = 5'($urandom_range(0, 7));
        end
        step(); reset = 1'b0; idle();
        repeat (10) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/writeback_arbiter.md
# writeback_arbiter

Merges results from the ALU and the load/store unit onto the register file's single write port (`portD_enable`/`portD_key`/`portD_value`). It tracks outstanding load destinations in a 32-entry pending scoreboard so the issue stage can stall on unready operands. It sits between the execute/memory stages and the register file, as the sole driver of the write port.

## Interface
Parameters:
- `LSU_FIFO_DEPTH`, default 2: LSU result skid buffer entries, power of two, ≥2.
- `STARVE_LIMIT`, default 4: consecutive ALU wins over a waiting LSU result before the LSU is forced; ≥1.

Ports:
- `clk` in 1: clock, all state on rising edge.
- `reset` in 1: synchronous, active-high.
- `alu_valid` in 1: ALU result present.
- `alu_ready` out 1: ALU result accepted this cycle.
- `alu_rd` in 5, `alu_value` in 32: ALU destination and data.
- `lsu_valid` in 1, `lsu_ready` out 1: LSU result handshake.
- `lsu_rd` in 5, `lsu_value` in 32: LSU destination and data.
- `pend_set` in 1, `pend_rd` in 5: issue stage marks a load destination pending.
- `query1_key` in 5, `query2_key` in 5: operand registers to check.
- `query1_busy` out 1, `query2_busy` out 1: operand has a load outstanding.
- `portD_enable` out 1, `portD_key` out 5, `portD_value` out 32: registered write port to the register file.

## Operation
- Handshakes: a transfer occurs when valid && ready in the same cycle. `lsu_ready` = FIFO not full and not in reset.
- Write-port register, next value, in priority order:
  1. Forced LSU, when the starve guard fires (see Configuration) and the FIFO is non-empty: pop the FIFO head; `alu_ready`=0.
  2. ALU accepted: write the ALU result.
  3. FIFO non-empty: pop the head.
  4. LSU accepted with FIFO empty: bypass straight to the port register.
  5. Otherwise `portD_enable`=0; key and value hold their last contents.
- An LSU transfer not bypassed is enqueued. Push and pop in the same cycle are legal, including when the FIFO is full (`lsu_ready` is 0 when full, so no push occurs then).
- Order: LSU results leave in arrival order. ALU results are never buffered.
- rd == 0: an accepted result with rd 0 is consumed and never asserts `portD_enable`. An ALU rd-0 transfer does not block a pending FIFO pop in that cycle.
- Scoreboard: 32 pending bits.
  - `pend_set` with nonzero `pend_rd` sets the bit.
  - An LSU-sourced write on `portD` clears `pending[portD_key]` on the following edge.
  - Set and clear of the same rd in the same cycle: set wins.
  - ALU writes never clear bits.
- `queryN_busy` = `pending[queryN_key]` && `queryN_key` != 0. This is combinational from the pending register; it does not see same-cycle sets.

## Timing
- Reset values:
  - `portD_enable`=0, `portD_key`=0, `portD_value`=0.
  - FIFO empty, all pending bits 0, starve counter 0.
  - `lsu_ready`=0 while `reset` is high; `alu_ready`=1.
- ALU latency: 1 cycle, from transfer edge to `portD` valid.
- LSU latency: 1 cycle when bypassed; otherwise 1 cycle after reaching the FIFO head and winning arbitration.
- `alu_ready` and `lsu_ready` depend only on registered state. There is no combinational valid→ready path.
- Reset mid-operation discards FIFO contents and pending bits. `portD_enable` is 0 from the first edge with `reset` high.
- Throughput: one write-port cycle per clock.

## Configuration
- `WB_STARVE_GUARD_EN` defined:
  - The counter increments on each cycle where the ALU wins while the FIFO is non-empty.
  - It resets to 0 on any FIFO pop or when the FIFO is empty.
  - When the count equals `STARVE_LIMIT`, the next cycle is a forced LSU cycle (`alu_ready`=0).
- Undefined: no counter; `alu_ready` is tied to 1, and the ALU always wins. LSU results may wait indefinitely under continuous ALU traffic.

## Test plan
- ALU rd=5 value 0xDEADBEEF, idle LSU → next cycle `portD_enable`=1, key 5, value 0xDEADBEEF.
- LSU rd=7 with ALU idle and FIFO empty → bypass; next cycle key 7. With `pend_set` rd=7 earlier, `query1_busy` (key 7) drops one cycle after the write.
- ALU and LSU both valid for 3 cycles (rd 1..3 / 9..11), depth 2 → `lsu_ready` falls after 2 enqueues; LSU writes 9, 10, 11 appear in order after the ALU burst.
- `WB_STARVE_GUARD_EN`, `STARVE_LIMIT`=4, ALU always valid, one LSU entry queued → 4 ALU writes, then one cycle with `alu_ready`=0 and the LSU write.
- `pend_set` rd=3 in the same cycle as an LSU write of rd 3 → bit stays set, `query2_busy`=1. Result with rd 0 → `portD_enable` stays 0.
- Assert `reset` with 2 FIFO entries and pending bits set → next cycle `portD_enable`=0, busy outputs 0, `lsu_ready`=1 after `reset` deasserts.
